// File: rtl/keypad_scanner.sv
// 4x3 keypad front end: row strobing, 2-flop column sync, per-scan snapshot,
// scan-level debounce and one-shot key events with held row/col levels.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_in,
  output logic [3:0] row_drive,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [3:0] pressed_row,
  output logic [2:0] pressed_col
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  function automatic logic [3:0] popcount12(input logic [11:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 12; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] first_index(input logic [11:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Sample position 3*row+col maps to the safe core's key code
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd9:    code = 4'hA;
      4'd10:   code = 4'h0;
      4'd11:   code = 4'hB;
      default: code = (idx < 4'd9) ? idx + 4'd1 : 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] onehot_of(input logic [3:0] idx);
    logic [6:0] rc;
    case (idx)
      4'd0:    rc = 7'b0001_001;
      4'd1:    rc = 7'b0001_010;
      4'd2:    rc = 7'b0001_100;
      4'd3:    rc = 7'b0010_001;
      4'd4:    rc = 7'b0010_010;
      4'd5:    rc = 7'b0010_100;
      4'd6:    rc = 7'b0100_001;
      4'd7:    rc = 7'b0100_010;
      4'd8:    rc = 7'b0100_100;
      4'd9:    rc = 7'b1000_001;
      4'd10:   rc = 7'b1000_010;
      4'd11:   rc = 7'b1000_100;
      default: rc = 7'b0000_000;
    endcase
    return rc;
  endfunction

  logic [2:0]    col_meta_r, col_sync_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    row_idx_r;
  logic [3:0]    row_drive_r;
  logic [8:0]    samples_r;
  logic          last_dwell_s, scan_end_s;
  logic [11:0]   snap_s;
  logic [3:0]    ones_s, key_idx_s;
  logic          is_key_s, is_none_s;
  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [3:0]    cand_r, cand_nxt_s;
  logic          press_evt_s, release_evt_s;
  logic          key_valid_r, key_valid_nxt_s;
  logic [3:0]    key_code_r, key_code_nxt_s;
  logic          key_held_r, key_held_nxt_s;
  logic [3:0]    pressed_row_r, pressed_row_nxt_s;
  logic [2:0]    pressed_col_r, pressed_col_nxt_s;

  // Two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r <= 3'b000;
      col_sync_r <= 3'b000;
    end else begin
      col_meta_r <= col_in;
      col_sync_r <= col_meta_r;
    end
  end

  assign last_dwell_s = (dwell_r == DWELL_LAST);
  assign scan_end_s   = last_dwell_s && (row_idx_r == 2'd3);

  // Row dwell timer, row strobe and end-of-dwell column samples for rows 1..3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r     <= '0;
      row_idx_r   <= 2'd0;
      row_drive_r <= 4'b0001;
      samples_r   <= 9'd0;
    end else if (last_dwell_s) begin
      dwell_r     <= '0;
      row_idx_r   <= row_idx_r + 2'd1;
      row_drive_r <= {row_drive_r[2:0], row_drive_r[3]};
      case (row_idx_r)
        2'd0:    samples_r[2:0] <= col_sync_r;
        2'd1:    samples_r[5:3] <= col_sync_r;
        2'd2:    samples_r[8:6] <= col_sync_r;
        default: samples_r      <= samples_r;
      endcase
    end else begin
      dwell_r <= dwell_r + DW'(1);
    end
  end

  // Row 4 is taken live from the synchronizer on the scan-end cycle itself
  always_comb begin
    snap_s    = {col_sync_r, samples_r};
    ones_s    = popcount12(snap_s);
    key_idx_s = first_index(snap_s);
    is_key_s  = (ones_s == 4'd1);
    is_none_s = (ones_s == 4'd0);
    cnt_inc_s = cnt_r + CNT_ONE;
  end

  // FSM state, debounce count and candidate key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      cand_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cand_r  <= cand_nxt_s;
    end
  end

  // Next-state logic, only advanced on the scan-end cycle
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    cand_nxt_s    = cand_r;
    press_evt_s   = 1'b0;
    release_evt_s = 1'b0;
    if (scan_end_s) begin
      case (state_r)
        ST_IDLE: begin
          if (is_key_s) begin
            cand_nxt_s = key_idx_s;
            if (DEBOUNCE_CNT == 1) begin
              state_nxt_s = ST_PRESSED;
              cnt_nxt_s   = CNT_ZERO;
              press_evt_s = 1'b1;
            end else begin
              state_nxt_s = ST_DEBOUNCE;
              cnt_nxt_s   = CNT_ONE;
            end
          end else begin
            cnt_nxt_s = CNT_ZERO;
          end
        end
        ST_DEBOUNCE: begin
          if (is_key_s && (key_idx_s == cand_r)) begin
            if (cnt_inc_s == CNT_DONE) begin
              state_nxt_s = ST_PRESSED;
              cnt_nxt_s   = CNT_ZERO;
              press_evt_s = 1'b1;
            end else begin
              cnt_nxt_s = cnt_inc_s;
            end
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        ST_PRESSED: begin
          if (is_none_s) begin
            if (DEBOUNCE_CNT == 1) begin
              state_nxt_s   = ST_IDLE;
              cnt_nxt_s     = CNT_ZERO;
              release_evt_s = 1'b1;
            end else begin
              state_nxt_s = ST_RELEASE;
              cnt_nxt_s   = CNT_ONE;
            end
          end else begin
            cnt_nxt_s = CNT_ZERO;
          end
        end
        ST_RELEASE: begin
          if (is_none_s) begin
            if (cnt_inc_s == CNT_DONE) begin
              state_nxt_s   = ST_IDLE;
              cnt_nxt_s     = CNT_ZERO;
              release_evt_s = 1'b1;
            end else begin
              cnt_nxt_s = cnt_inc_s;
            end
          end else begin
            state_nxt_s = ST_PRESSED;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output values for the edge that enters PRESSED or returns to IDLE
  always_comb begin
    key_valid_nxt_s   = 1'b0;
    key_code_nxt_s    = key_code_r;
    key_held_nxt_s    = key_held_r;
    pressed_row_nxt_s = pressed_row_r;
    pressed_col_nxt_s = pressed_col_r;
    if (press_evt_s) begin
      key_valid_nxt_s = 1'b1;
      key_code_nxt_s  = code_of(cand_nxt_s);
      key_held_nxt_s  = 1'b1;
      {pressed_row_nxt_s, pressed_col_nxt_s} = onehot_of(cand_nxt_s);
    end else if (release_evt_s) begin
      key_held_nxt_s    = 1'b0;
      pressed_row_nxt_s = 4'b0000;
      pressed_col_nxt_s = 3'b000;
    end else begin
      key_valid_nxt_s = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_r   <= 1'b0;
      key_code_r    <= 4'h0;
      key_held_r    <= 1'b0;
      pressed_row_r <= 4'b0000;
      pressed_col_r <= 3'b000;
    end else begin
      key_valid_r   <= key_valid_nxt_s;
      key_code_r    <= key_code_nxt_s;
      key_held_r    <= key_held_nxt_s;
      pressed_row_r <= pressed_row_nxt_s;
      pressed_col_r <= pressed_col_nxt_s;
    end
  end

  assign row_drive   = row_drive_r;
  assign key_valid   = key_valid_r;
  assign key_code    = key_code_r;
  assign key_held    = key_held_r;
  assign pressed_row = pressed_row_r;
  assign pressed_col = pressed_col_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives col_in from row_drive; scan-level
// reference model plus a hand-derived per-scan table and a mid-debounce reset sequence.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int SCAN_CLK     = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] col_in;
  logic [3:0] row_drive;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [3:0] pressed_row;
  logic [2:0] pressed_col;
  logic [11:0] keys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] mask;
    logic        valid;
    logic        held;
    logic [3:0]  code;
    logic [3:0]  prow;
    logic [2:0]  pcol;
  } vec_t;
  vec_t tbl[$];

  // reference model state (scan granularity)
  logic       m_held, m_evt;
  logic [3:0] m_code, m_prow;
  logic [2:0] m_pcol;
  int         m_run_key, m_run_len, m_rel_len;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_drive(row_drive),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
    .pressed_row(pressed_row), .pressed_col(pressed_col)
  );

  always #5 clk = ~clk;

  // pressed switch at (r,c) connects row r to column c
  always_comb begin
    col_in = 3'b000;
    for (int r = 0; r < 4; r++) begin
      if (row_drive[r]) col_in = col_in | keys[3*r +: 3];
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(input int p);
    int r, c;
    r = p / 3;
    c = p % 3;
    if (r < 3) return 4'(3 * r + c + 1);
    if (c == 0) return 4'hA;
    if (c == 1) return 4'h0;
    return 4'hB;
  endfunction

  task automatic model_reset();
    m_held = 1'b0; m_evt = 1'b0; m_code = 4'h0; m_prow = 4'b0; m_pcol = 3'b0;
    m_run_key = -1; m_run_len = 0; m_rel_len = 0;
  endtask

  task automatic model_scan(input logic [11:0] m);
    int n, p;
    n = $countones(m);
    p = -1;
    for (int i = 0; i < 12; i++) if (m[i]) p = i;
    m_evt = 1'b0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run_len == 0) begin m_run_key = p; m_run_len = 1; end
        else if (p == m_run_key) m_run_len++;
        else m_run_len = 0;
      end else m_run_len = 0;
      if (m_run_len == DEBOUNCE_CNT) begin
        m_evt = 1'b1; m_held = 1'b1; m_code = code_of(p);
        m_prow = 4'(1 << (p / 3)); m_pcol = 3'(1 << (p % 3));
        m_run_len = 0; m_rel_len = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel_len++;
        if (m_rel_len == DEBOUNCE_CNT) begin
          m_held = 1'b0; m_prow = 4'b0; m_pcol = 3'b0; m_rel_len = 0;
        end
      end else m_rel_len = 0;
    end
  endtask

  // one full scan starting at a negedge where the dwell counter is 0 on row 1
  task automatic run_scan(input logic [11:0] m);
    keys = m;
    for (int i = 0; i < SCAN_CLK; i++) begin
      chk("row_drive", 16'(row_drive), 16'(1 << (i / SCAN_DIV)));
      chk("key_valid", 16'(key_valid), 16'((i == 0) ? m_evt : 1'b0));
      chk("key_held", 16'(key_held), 16'(m_held));
      chk("key_code", 16'(key_code), 16'(m_code));
      chk("pressed_row", 16'(pressed_row), 16'(m_prow));
      chk("pressed_col", 16'(pressed_col), 16'(m_pcol));
      @(posedge clk);
      @(negedge clk);
    end
    model_scan(m);
  endtask

  task automatic add_vec(input logic [11:0] mask, input logic v, input logic h,
                         input logic [3:0] code, input logic [3:0] prow, input logic [2:0] pcol);
    vec_t e;
    e.mask = mask; e.valid = v; e.held = h; e.code = code; e.prow = prow; e.pcol = pcol;
    tbl.push_back(e);
  endtask

  task automatic add_n(input int n, input logic [11:0] mask, input logic v, input logic h,
                       input logic [3:0] code, input logic [3:0] prow, input logic [2:0] pcol);
    for (int i = 0; i < n; i++) add_vec(mask, v, h, code, prow, pcol);
  endtask

  task automatic chk_outputs(input string tag, input logic v, input logic h, input logic [3:0] code,
                             input logic [3:0] prow, input logic [2:0] pcol);
    chk({tag, "_valid"}, 16'(key_valid), 16'(v));
    chk({tag, "_held"}, 16'(key_held), 16'(h));
    chk({tag, "_code"}, 16'(key_code), 16'(code));
    chk({tag, "_prow"}, 16'(pressed_row), 16'(prow));
    chk({tag, "_pcol"}, 16'(pressed_col), 16'(pcol));
  endtask

  localparam logic [11:0] K1  = 12'h001;
  localparam logic [11:0] K5  = 12'h010;
  localparam logic [11:0] K6  = 12'h020;
  localparam logic [11:0] KA  = 12'h200;
  localparam logic [11:0] KB  = 12'h800;
  localparam logic [11:0] K15 = 12'h011;
  localparam logic [11:0] NO  = 12'h000;

  initial begin
    logic [11:0] prev, m;
    rst_n = 1'b0;
    keys  = NO;
    model_reset();

    // table: mask applied for one scan, outputs expected right after that scan
    add_n(4, NO, 1'b0, 1'b0, 4'h0, 4'b0000, 3'b000);
    add_n(2, K6, 1'b0, 1'b0, 4'h0, 4'b0000, 3'b000);
    add_n(1, K6, 1'b1, 1'b1, 4'h6, 4'b0010, 3'b100);
    add_n(2, K6, 1'b0, 1'b1, 4'h6, 4'b0010, 3'b100);
    add_n(2, NO, 1'b0, 1'b1, 4'h6, 4'b0010, 3'b100);
    add_n(1, NO, 1'b0, 1'b0, 4'h6, 4'b0000, 3'b000);
    add_n(2, KA, 1'b0, 1'b0, 4'h6, 4'b0000, 3'b000);
    add_n(1, KA, 1'b1, 1'b1, 4'hA, 4'b1000, 3'b001);
    add_n(2, NO, 1'b0, 1'b1, 4'hA, 4'b1000, 3'b001);
    add_n(1, NO, 1'b0, 1'b0, 4'hA, 4'b0000, 3'b000);
    add_n(2, KB, 1'b0, 1'b0, 4'hA, 4'b0000, 3'b000);
    add_n(1, KB, 1'b1, 1'b1, 4'hB, 4'b1000, 3'b100);
    add_n(2, NO, 1'b0, 1'b1, 4'hB, 4'b1000, 3'b100);
    add_n(1, NO, 1'b0, 1'b0, 4'hB, 4'b0000, 3'b000);
    add_n(2, K5, 1'b0, 1'b0, 4'hB, 4'b0000, 3'b000);
    add_n(1, NO, 1'b0, 1'b0, 4'hB, 4'b0000, 3'b000);
    add_n(2, K5, 1'b0, 1'b0, 4'hB, 4'b0000, 3'b000);
    add_n(1, K5, 1'b1, 1'b1, 4'h5, 4'b0010, 3'b010);
    add_n(2, NO, 1'b0, 1'b1, 4'h5, 4'b0010, 3'b010);
    add_n(1, NO, 1'b0, 1'b0, 4'h5, 4'b0000, 3'b000);
    add_n(4, K15, 1'b0, 1'b0, 4'h5, 4'b0000, 3'b000);
    add_n(2, K1, 1'b0, 1'b0, 4'h5, 4'b0000, 3'b000);
    add_n(1, K1, 1'b1, 1'b1, 4'h1, 4'b0001, 3'b001);
    add_n(3, K15, 1'b0, 1'b1, 4'h1, 4'b0001, 3'b001);
    add_n(2, NO, 1'b0, 1'b1, 4'h1, 4'b0001, 3'b001);
    add_n(1, NO, 1'b0, 1'b0, 4'h1, 4'b0000, 3'b000);

    repeat (3) @(negedge clk);
    chk("reset_row_drive", 16'(row_drive), 16'h0001);
    chk_outputs("reset", 1'b0, 1'b0, 4'h0, 4'b0000, 3'b000);
    rst_n = 1'b1;

    for (int j = 0; j < tbl.size(); j++) begin
      run_scan(tbl[j].mask);
      chk_outputs("tbl", tbl[j].valid, tbl[j].held, tbl[j].code, tbl[j].prow, tbl[j].pcol);
    end

    // reset while key 6 is two scans into debounce
    run_scan(K6);
    run_scan(K6);
    keys = K6;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    chk("midrst_row_drive", 16'(row_drive), 16'h0001);
    chk_outputs("midrst", 1'b0, 1'b0, 4'h0, 4'b0000, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_scan(K6);
    chk_outputs("post_rst1", 1'b0, 1'b0, 4'h0, 4'b0000, 3'b000);
    run_scan(K6);
    chk_outputs("post_rst2", 1'b0, 1'b0, 4'h0, 4'b0000, 3'b000);
    run_scan(K6);
    chk_outputs("post_rst3", 1'b1, 1'b1, 4'h6, 4'b0010, 3'b100);
    repeat (3) run_scan(NO);
    chk_outputs("post_rst_rel", 1'b0, 1'b0, 4'h6, 4'b0000, 3'b000);

    // randomized scans against the reference model
    prev = NO;
    for (int s = 0; s < 80; s++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 40) m = prev;
      else if (sel < 65) m = NO;
      else if (sel < 90) m = 12'(1 << $urandom_range(0, 11));
      else m = 12'((1 << $urandom_range(0, 11)) | (1 << $urandom_range(0, 11)));
      run_scan(m);
      prev = m;
    end
    repeat (3) run_scan(NO);
    run_scan(NO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
